// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: H/V region FSMs, coordinates, syncs, display window and strobes.
// Optional frame counter output is enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int H_VISIBLE = 1024,
    parameter int H_FRONT   = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BACK    = 160,
    parameter int V_VISIBLE = 768,
    parameter int V_FRONT   = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BACK    = 29,
    parameter int H_POL     = 0,
    parameter int V_POL     = 0,
    parameter int XW        = 11,
    parameter int YW        = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          hsync,
    output logic          vsync,
    output logic          display,
    output logic          line_end,
    output logic          frame_end
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [1:0] H_ACT = 2'd0, H_FP = 2'd1, H_SP = 2'd2, H_BP = 2'd3;
    localparam logic [1:0] V_ACT = 2'd0, V_FP = 2'd1, V_SP = 2'd2, V_BP = 2'd3;

    localparam logic H_ON = (H_POL != 0) ? 1'b1 : 1'b0;
    localparam logic V_ON = (V_POL != 0) ? 1'b1 : 1'b0;

    localparam logic [XW-1:0] H_ACT_END = XW'(H_VISIBLE - 1);
    localparam logic [XW-1:0] H_FP_END  = XW'(H_VISIBLE + H_FRONT - 1);
    localparam logic [XW-1:0] H_SP_END  = XW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [XW-1:0] H_LAST    = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT_END = YW'(V_VISIBLE - 1);
    localparam logic [YW-1:0] V_FP_END  = YW'(V_VISIBLE + V_FRONT - 1);
    localparam logic [YW-1:0] V_SP_END  = YW'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [YW-1:0] V_LAST    = YW'(V_TOTAL - 1);

    // First region at or after 'from' with non-zero width; wraps back to the active region.
    function automatic logic [1:0] first_live(input logic [1:0] from, input int w_fp,
                                              input int w_sp, input int w_bp);
        logic [1:0] r;
        if (from <= 2'd1 && w_fp != 0) r = 2'd1;
        else if (from <= 2'd2 && w_sp != 0) r = 2'd2;
        else if (w_bp != 0) r = 2'd3;
        else r = 2'd0;
        return r;
    endfunction

    localparam logic [1:0] H_AFTER_ACT = first_live(2'd1, H_FRONT, H_SYNC, H_BACK);
    localparam logic [1:0] H_AFTER_FP  = first_live(2'd2, H_FRONT, H_SYNC, H_BACK);
    localparam logic [1:0] H_AFTER_SP  = first_live(2'd3, H_FRONT, H_SYNC, H_BACK);
    localparam logic [1:0] V_AFTER_ACT = first_live(2'd1, V_FRONT, V_SYNC, V_BACK);
    localparam logic [1:0] V_AFTER_FP  = first_live(2'd2, V_FRONT, V_SYNC, V_BACK);
    localparam logic [1:0] V_AFTER_SP  = first_live(2'd3, V_FRONT, V_SYNC, V_BACK);

    logic [1:0]    h_state_r, h_state_s;
    logic [1:0]    v_state_r, v_state_s;
    logic [XW-1:0] x_nxt_s;
    logic [YW-1:0] y_nxt_s;
    logic          eol_s;
    logic          hsync_s, vsync_s, display_s, line_end_s, frame_end_s;

    // Next coordinates; y steps only on the x wrap.
    always_comb begin
        eol_s   = (x == H_LAST);
        x_nxt_s = eol_s ? {XW{1'b0}} : x + XW'(1);
        if (eol_s) begin
            y_nxt_s = (y == V_LAST) ? {YW{1'b0}} : y + YW'(1);
        end else begin
            y_nxt_s = y;
        end
    end

    // Region FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_state_r <= H_ACT;
            v_state_r <= V_ACT;
        end else if (en) begin
            h_state_r <= h_state_s;
            v_state_r <= v_state_s;
        end
    end

    // Region FSM next state: leave a region on its last pixel/line.
    always_comb begin
        h_state_s = h_state_r;
        case (h_state_r)
            H_ACT:   if (x == H_ACT_END) h_state_s = H_AFTER_ACT; else h_state_s = H_ACT;
            H_FP:    if (x == H_FP_END)  h_state_s = H_AFTER_FP;  else h_state_s = H_FP;
            H_SP:    if (x == H_SP_END)  h_state_s = H_AFTER_SP;  else h_state_s = H_SP;
            H_BP:    if (x == H_LAST)    h_state_s = H_ACT;       else h_state_s = H_BP;
            default: h_state_s = H_ACT;
        endcase
        v_state_s = v_state_r;
        case (v_state_r)
            V_ACT:   if (eol_s && y == V_ACT_END) v_state_s = V_AFTER_ACT; else v_state_s = V_ACT;
            V_FP:    if (eol_s && y == V_FP_END)  v_state_s = V_AFTER_FP;  else v_state_s = V_FP;
            V_SP:    if (eol_s && y == V_SP_END)  v_state_s = V_AFTER_SP;  else v_state_s = V_SP;
            V_BP:    if (eol_s && y == V_LAST)    v_state_s = V_ACT;       else v_state_s = V_BP;
            default: v_state_s = V_ACT;
        endcase
    end

    // Output decode from next state/coordinates so registered outputs line up with x/y.
    always_comb begin
        hsync_s     = (h_state_s == H_SP) ? H_ON : ~H_ON;
        vsync_s     = (v_state_s == V_SP) ? V_ON : ~V_ON;
        display_s   = (h_state_s == H_ACT) && (v_state_s == V_ACT);
        line_end_s  = (x_nxt_s == H_LAST);
        frame_end_s = line_end_s && (y_nxt_s == V_LAST);
    end

    // Output registers; everything holds while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x         <= {XW{1'b0}};
            y         <= {YW{1'b0}};
            hsync     <= ~H_ON;
            vsync     <= ~V_ON;
            display   <= 1'b1;
            line_end  <= 1'b0;
            frame_end <= 1'b0;
        end else if (en) begin
            x         <= x_nxt_s;
            y         <= y_nxt_s;
            hsync     <= hsync_s;
            vsync     <= vsync_s;
            display   <= display_s;
            line_end  <= line_end_s;
            frame_end <= frame_end_s;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Frame counter bumps on the wrap out of the last pixel of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 16'd0;
        end else if (en && frame_end) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 14x8 raster, with an active-low and an active-high instance.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [3:0] x, xp;
    logic [2:0] y, yp;
    logic hs, vs, de, le, fe;
    logic hsp, vsp, dep, lep, fep;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fc, fcp;
`endif

    always #5 clk = ~clk;

    vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
                     .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                     .H_POL(0), .V_POL(0), .XW(4), .YW(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .x(x), .y(y), .hsync(hs), .vsync(vs),
        .display(de), .line_end(le), .frame_end(fe)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc)
`endif
    );

    vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
                     .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                     .H_POL(1), .V_POL(1), .XW(4), .YW(3)) dut_p (
        .clk(clk), .rst_n(rst_n), .en(en), .x(xp), .y(yp), .hsync(hsp), .vsync(vsp),
        .display(dep), .line_end(lep), .frame_end(fep)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fcp)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        tick();
        tick();
        checks++;
        if ({x, y, hs, vs, de, le, fe} !== {4'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_low got x=%0d y=%0d hs=%b vs=%b de=%b le=%b fe=%b exp 0 0 1 1 1 0 0",
                     x, y, hs, vs, de, le, fe);
        end
        checks++;
        if ({xp, yp, hsp, vsp, dep, lep, fep} !== {4'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_high got x=%0d y=%0d hs=%b vs=%b de=%b le=%b fe=%b exp 0 0 0 0 1 0 0",
                     xp, yp, hsp, vsp, dep, lep, fep);
        end
    endtask

    task automatic test_frame();
        int fe_cnt = 0;
        int le_cnt = 0;
        rst_n = 1'b1;
        en    = 1'b1;
        for (int k = 1; k <= 112; k++) begin
            int ex, ey;
            logic ehs, evs, ede, ele, efe;
            tick();
            ex  = k % 14;
            ey  = (k / 14) % 8;
            ehs = !(ex >= 10 && ex <= 12);
            evs = !(ey >= 5 && ey <= 6);
            ede = (ex < 8) && (ey < 4);
            ele = (ex == 13);
            efe = (ex == 13) && (ey == 7);
            checks++;
            if ({x, y, hs, vs, de, le, fe} !== {4'(ex), 3'(ey), ehs, evs, ede, ele, efe}) begin
                errors++;
                $display("FAIL frame k=%0d got x=%0d y=%0d hs=%b vs=%b de=%b le=%b fe=%b exp %0d %0d %b %b %b %b %b",
                         k, x, y, hs, vs, de, le, fe, ex, ey, ehs, evs, ede, ele, efe);
            end
            fe_cnt += int'(fe);
            le_cnt += int'(le);
        end
        checks++;
        if (fe_cnt != 1) begin
            errors++;
            $display("FAIL frame_end_count got %0d exp 1", fe_cnt);
        end
        checks++;
        if (le_cnt != 8) begin
            errors++;
            $display("FAIL line_end_count got %0d exp 8", le_cnt);
        end
        checks++;
        if ({x, y} !== {4'd0, 3'd0}) begin
            errors++;
            $display("FAIL frame_wrap got x=%0d y=%0d exp 0 0", x, y);
        end
    endtask

    task automatic test_polarity();
        int vs_low = 0;
        int hs_low = 0;
        for (int k = 1; k <= 112; k++) begin
            int ex, ey;
            logic ehs, evs;
            tick();
            ex  = k % 14;
            ey  = (k / 14) % 8;
            ehs = (ex >= 10 && ex <= 12);
            evs = (ey >= 5 && ey <= 6);
            checks++;
            if ({xp, yp, hsp, vsp} !== {4'(ex), 3'(ey), ehs, evs}) begin
                errors++;
                $display("FAIL polarity k=%0d got x=%0d y=%0d hs=%b vs=%b exp %0d %0d %b %b",
                         k, xp, yp, hsp, vsp, ex, ey, ehs, evs);
            end
            vs_low += int'(!vs);
            hs_low += int'(!hs);
        end
        checks++;
        if (vs_low != 28) begin
            errors++;
            $display("FAIL vsync_low_cycles got %0d exp 28", vs_low);
        end
        checks++;
        if (hs_low != 24) begin
            errors++;
            $display("FAIL hsync_low_cycles got %0d exp 24", hs_low);
        end
    endtask

    task automatic test_en_hold();
        repeat (9) tick();
        checks++;
        if ({x, y} !== {4'd9, 3'd0}) begin
            errors++;
            $display("FAIL en_pre got x=%0d y=%0d exp 9 0", x, y);
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({x, y, hs, vs, de, le, fe} !== {4'd9, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL en_hold i=%0d got x=%0d y=%0d hs=%b vs=%b de=%b le=%b fe=%b exp 9 0 1 1 0 0 0",
                         i, x, y, hs, vs, de, le, fe);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if ({x, hs} !== {4'd10, 1'b0}) begin
            errors++;
            $display("FAIL en_resume got x=%0d hs=%b exp 10 0", x, hs);
        end
        repeat (3) tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({x, le} !== {4'd13, 1'b1}) begin
                errors++;
                $display("FAIL strobe_hold i=%0d got x=%0d le=%b exp 13 1", i, x, le);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if ({x, y, le} !== {4'd0, 3'd1, 1'b0}) begin
            errors++;
            $display("FAIL strobe_release got x=%0d y=%0d le=%b exp 0 1 0", x, y, le);
        end
    endtask

    task automatic test_async_reset();
        repeat (67) tick();
        checks++;
        if ({x, y, hs, vs} !== {4'd11, 3'd5, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL pre_reset got x=%0d y=%0d hs=%b vs=%b exp 11 5 0 0", x, y, hs, vs);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({x, y, hs, vs, de, le, fe} !== {4'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got x=%0d y=%0d hs=%b vs=%b de=%b le=%b fe=%b exp 0 0 1 1 1 0 0",
                     x, y, hs, vs, de, le, fe);
        end
        checks++;
        if ({hsp, vsp} !== {1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset_pol got hs=%b vs=%b exp 0 0", hsp, vsp);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({x, y} !== {4'd1, 3'd0}) begin
            errors++;
            $display("FAIL post_reset got x=%0d y=%0d exp 1 0", x, y);
        end
        repeat (13) tick();
        checks++;
        if ({x, y} !== {4'd0, 3'd1}) begin
            errors++;
            $display("FAIL post_reset_line got x=%0d y=%0d exp 0 1", x, y);
        end
    endtask

`ifdef VGA_FRAME_CNT_EN
    task automatic test_frame_cnt();
        rst_n = 1'b0;
        tick();
        checks++;
        if (fc !== 16'd0) begin
            errors++;
            $display("FAIL frame_cnt_reset got %0d exp 0", fc);
        end
        rst_n = 1'b1;
        for (int f = 1; f <= 3; f++) begin
            repeat (112) tick();
            checks++;
            if ({fc, x, y} !== {16'(f), 4'd0, 3'd0}) begin
                errors++;
                $display("FAIL frame_cnt f=%0d got cnt=%0d x=%0d y=%0d exp %0d 0 0", f, fc, x, y, f);
            end
        end
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        tick();
        checks++;
        if (fc !== 16'hFFFF) begin
            errors++;
            $display("FAIL frame_cnt_preload got %h exp ffff", fc);
        end
        repeat (111) tick();
        checks++;
        if (fc !== 16'd0) begin
            errors++;
            $display("FAIL frame_cnt_wrap got %h exp 0000", fc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_polarity();
        test_en_hold();
        test_async_reset();
`ifdef VGA_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
